// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential shift-and-add multiplier. Signed operands are
//               multiplied as magnitudes, and the result is negated at the end
//               when the operand signs differ. The latency is WIDTH+1 clock
//               edges from start to done.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int                 c_CW     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   c_ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] c_ONE_2W = (2*WIDTH)'(1);
  localparam logic [c_CW-1:0]    c_CNT_LD = c_CW'(WIDTH);
  localparam logic [c_CW-1:0]    c_CNT_1  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CW-1:0]      r_cnt;
  logic [WIDTH-1:0]     r_mcand;     // multiplicand magnitude
  logic [WIDTH-1:0]     r_hi;        // upper half of accumulator
  logic [WIDTH-1:0]     r_lo;        // multiplier, shifted out as product bits shift in
  logic                 r_sign;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_raw;
  logic [2*WIDTH-1:0]   w_result;

  // Operand magnitudes: in signed mode, a negative value is negated. The most
  // negative value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  always_comb begin
    w_a_mag = multiplicand;
    w_b_mag = multiplier;
    if (signed_mode && multiplicand[WIDTH-1]) w_a_mag = ~multiplicand + c_ONE_W;
    if (signed_mode && multiplier[WIDTH-1])   w_b_mag = ~multiplier + c_ONE_W;
  end

  // One iteration adds the multiplicand into the upper half and keeps the carry.
  // The final result is negated when the sign flag is set.
  always_comb begin
    w_addend = r_lo[0] ? r_mcand : '0;
    w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    w_raw    = {r_hi, r_lo};
    w_result = r_sign ? (~w_raw + c_ONE_2W) : w_raw;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_a_mag;
            r_lo    <= w_b_mag;
            r_hi    <= '0;
            r_sign  <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            r_cnt   <= c_CNT_LD;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_hi  <= w_sum[WIDTH:1];
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt - c_CNT_1;
          if (r_cnt == c_CNT_1) r_state <= S_FIN;
        end
        S_FIN: begin
          r_product <= w_result;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Self-checking bench for shift_add_mult (WIDTH=8). Directed
//               and random operations are compared against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

  localparam int c_W = 8;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [c_W-1:0]   multiplicand = '0;
  logic [c_W-1:0]   multiplier = '0;
  logic             busy;
  logic             done;
  logic [2*c_W-1:0] product;

  int errs = 0;
  int checks = 0;
  logic [15:0] last_prod = 16'h0000;

  shift_add_mult #(.WIDTH(c_W)) dut (
    .clk          (clk),
    .res          (res),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arithmetic model: plain integer product, truncated to 2*WIDTH bits.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic signed [31:0] p;
    if (sm) p = 32'(signed'(a)) * 32'(signed'(b));
    else    p = 32'({24'd0, a}) * 32'({24'd0, b});
    return p[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one operation. On return we are just past the edge that raised done,
  // so a following call drives start during the done cycle (back-to-back).
  // If noisy is set, start is pulsed with 7*7 while busy; it must be ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input bit noisy);
    logic [15:0] exp;
    int n;
    bit busy_ok;
    bit hold_ok;
    exp = ref_prod(a, b, sm);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sm;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    signed_mode  = 1'($urandom);
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    n = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n < 20) begin
      if (noisy && n >= 1 && n <= 7) begin
        start = 1'b1; multiplicand = 8'd7; multiplier = 8'd7; signed_mode = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (product !== last_prod) hold_ok = 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, 32'd9);
    check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_product_held"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
    check({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
    last_prod = exp;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    start = 1'b1;                      // must be ignored while in reset
    multiplicand = 8'd9; multiplier = 8'd9;
    step(); step();
    start = 1'b0;
    check("reset_start_ignored", {31'd0, busy}, 32'd0);
    res = 1'b0;
    step();

    // Directed values
    run_op("u13x11", 8'd13, 8'd11, 1'b0, 1'b0);
    step();
    run_op("u255x255", 8'd255, 8'd255, 1'b0, 1'b0);
    check("u255x255_value", {16'd0, product}, 32'h0000FE01);
    step();
    run_op("s_m3x5", 8'hFD, 8'd5, 1'b1, 1'b0);
    check("s_m3x5_value", {16'd0, product}, 32'h0000FFF1);
    step();
    run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 1'b0);
    check("s_m128xm128_value", {16'd0, product}, 32'h00004000);
    step();
    run_op("s_m128x127", 8'h80, 8'h7F, 1'b1, 1'b0);
    check("s_m128x127_value", {16'd0, product}, 32'h0000C080);
    step();

    // Starts while busy are ignored
    run_op("noisy13x11", 8'd13, 8'd11, 1'b0, 1'b1);
    check("noisy_value", {16'd0, product}, 32'h0000008F);
    step();
    check("noisy_single_done", {31'd0, done}, 32'd0);
    check("noisy_no_restart", {31'd0, busy}, 32'd0);

    // Back-to-back: the second start lands in the done cycle
    run_op("b2b_first", 8'd13, 8'd11, 1'b0, 1'b0);
    run_op("b2b_second", 8'd6, 8'd7, 1'b0, 1'b0);
    check("b2b_value", {16'd0, product}, 32'h0000002A);
    step();

    // Zero operands
    run_op("u0x200", 8'd0, 8'd200, 1'b0, 1'b0);
    check("u0x200_value", {16'd0, product}, 32'h00000000);
    run_op("s0xm5", 8'd0, 8'hFB, 1'b1, 1'b0);
    check("s0xm5_value", {16'd0, product}, 32'h00000000);
    step();

    // Asynchronous reset in the middle of an operation
    run_op("pre_abort", 8'd3, 8'd3, 1'b0, 1'b0);
    multiplicand = 8'd255; multiplier = 8'd255; signed_mode = 1'b0; start = 1'b1;
    step();                            // E0
    start = 1'b0;
    step(); step(); step();            // into the 4th RUN cycle
    #2 res = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    last_prod = 16'h0000;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (done) saw_done = 1'b1;
      end
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
    end
    run_op("after_abort_2x3", 8'd2, 8'd3, 1'b0, 1'b0);
    check("after_abort_value", {16'd0, product}, 32'h00000006);

    // Random operations with random gaps (zero gap = back-to-back)
    for (int k = 0; k < 30; k++) begin
      int gap;
      run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port res  input  1  reset, asynchronous, active-high.
REQ-004 Port start  input  1  request pulse; sampled on a clk rising edge.
REQ-005 Port signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; sampled with start.
REQ-006 Port multiplicand  input  WIDTH  operand A; sampled with start.
REQ-007 Port multiplier  input  WIDTH  operand B; sampled with start.
REQ-008 Port busy  output  1  high while an operation is in progress.
REQ-009 Port done  output  1  single-cycle pulse; product is valid in this cycle.
REQ-010 Port product  output  2*WIDTH  registered result; holds its value until the next done.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and FIN.
REQ-012 In IDLE with start=1 at edge E0, the block SHALL latch the operands and mode, set the iteration counter to WIDTH, clear the accumulator, and enter RUN.
REQ-013 In signed mode, the block SHALL latch |A| and |B| as WIDTH-bit unsigned magnitudes and a sign flag equal to sign(A) XOR sign(B).
REQ-014 The magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), which is representable without overflow.
REQ-015 In unsigned mode, the sign flag SHALL be 0.
REQ-016 Each RUN edge SHALL perform one iteration:
 - if the multiplier LSB is 1, add the multiplicand to the upper WIDTH bits of the accumulator, using a WIDTH+1-bit sum so the carry is kept;
 - shift the {carry, accumulator, multiplier} register right by 1;
 - decrement the counter.
REQ-017 After WIDTH RUN edges (E1..E_WIDTH), the FSM SHALL enter FIN.
REQ-018 At edge E_WIDTH+1 (leaving FIN), product SHALL load the 2*WIDTH-bit result, two's-complement negated if the sign flag is 1.
REQ-019 The same edge (E_WIDTH+1) SHALL assert done for exactly one cycle.
REQ-020 Total latency SHALL be WIDTH+1 edges from the edge sampling start to the edge raising done.
REQ-021 busy SHALL be 1 from after E0 through E_WIDTH+1, and 0 in the cycle in which done=1.
REQ-022 start while busy=1 SHALL be ignored; operands and mode captured at E0 SHALL remain unaffected.
REQ-023 start in the cycle in which done=1 SHALL be accepted as a new E0 (back-to-back operation); product SHALL hold until that operation's done.
REQ-024 A zero operand SHALL still take the full latency and yield product=0, with no negative zero.
REQ-025 In unsigned mode, the full product SHALL always fit in 2*WIDTH bits with no truncation.
REQ-026 In signed mode, the full product SHALL fit in 2*WIDTH bits, including (-2^(WIDTH-1))^2.
REQ-027 Operand inputs SHALL be don't-care outside the cycle in which start is accepted.

Reset
REQ-028 res=1 SHALL immediately, without waiting for clk, force:
 - FSM to IDLE;
 - busy=0, done=0, product=0;
 - counter, accumulator and sign flag to 0.
REQ-029 res asserted mid-operation SHALL abort the operation; no done SHALL be produced for it.
REQ-030 After res deasserts, the first start SHALL begin a fresh operation.
REQ-031 start sampled while res=1 SHALL be ignored.

Verification (WIDTH=8)
REQ-032 Unsigned 13*11 -> done exactly 9 edges after start, product=0x008F; 255*255 -> 0xFE01.
REQ-033 Signed -3*5 -> 0xFFF1; -128*-128 -> 0x4000; -128*127 -> 0xC080.
REQ-034 start pulses again at cycles 2..8 of a 13*11 run, with new operands 7*7 -> exactly one done, product=0x008F.
REQ-035 Back-to-back: second start (6*7) during the done cycle of 13*11 -> product 0x008F held until the next done, then 0x002A; busy never drops for more than the one done cycle.
REQ-036 res pulse at the 4th RUN cycle of 255*255 -> busy=0 and product=0 immediately; no done; following 2*3 -> 0x0006.
REQ-037 0*200 unsigned and 0*(-5) signed -> product=0x0000 with full 9-edge latency.
